// File: rtl/traffic_phase_sequencer.sv
// Timed RED -> RED+YELLOW -> GREEN -> YELLOW phase sequencer.
// Define TLS_PED_EN to enable pedestrian early-green and ped_ack.
module traffic_phase_sequencer #(
  parameter int RED_CYCLES       = 16,
  parameter int RY_CYCLES        = 4,
  parameter int GREEN_CYCLES     = 20,
  parameter int MIN_GREEN_CYCLES = 8,
  parameter int YELLOW_CYCLES    = 6,
  parameter int CNT_W            = 8
) (
  input  logic clk,
  input  logic rstb,
  input  logic enable,
  input  logic ped_req,
  output logic ped_ack,
  output logic phase_a,
  output logic phase_b,
  output logic phase_start
);

  localparam longint MAX_DUR = 64'(1) << CNT_W;

  if (RED_CYCLES < 1 || RED_CYCLES > MAX_DUR) begin : g_bad_red
    $error("RED_CYCLES out of range");
  end
  if (RY_CYCLES < 1 || RY_CYCLES > MAX_DUR) begin : g_bad_ry
    $error("RY_CYCLES out of range");
  end
  if (GREEN_CYCLES < 1 || GREEN_CYCLES > MAX_DUR) begin : g_bad_grn
    $error("GREEN_CYCLES out of range");
  end
  if (YELLOW_CYCLES < 1 || YELLOW_CYCLES > MAX_DUR) begin : g_bad_yel
    $error("YELLOW_CYCLES out of range");
  end
  if (MIN_GREEN_CYCLES < 1 ||
      MIN_GREEN_CYCLES > GREEN_CYCLES) begin : g_bad_min
    $error("MIN_GREEN_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    RED = 2'b00,
    RY  = 2'b01,
    GRN = 2'b10,
    YEL = 2'b11
  } phase_t;

  localparam logic [CNT_W-1:0] RED_LD = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] RY_LD  = CNT_W'(RY_CYCLES - 1);
  localparam logic [CNT_W-1:0] GRN_LD = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YEL_LD = CNT_W'(YELLOW_CYCLES - 1);

  phase_t           state;
  phase_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             early;
  logic             done;

  function automatic logic [CNT_W-1:0] load_val(input phase_t p);
    logic [CNT_W-1:0] v;
    v = RED_LD;
    unique case (p)
      RED: v = RED_LD;
      RY:  v = RY_LD;
      GRN: v = GRN_LD;
      YEL: v = YEL_LD;
    endcase
    return v;
  endfunction

  assign done = enable && (cnt == '0 || early);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= RED;
      cnt         <= RED_LD;
      phase_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      phase_start <= done;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (done) begin
      unique case (state)
        RED: state_nxt = RY;
        RY:  state_nxt = GRN;
        GRN: state_nxt = YEL;
        YEL: state_nxt = RED;
      endcase
      cnt_nxt = load_val(state_nxt);
    end else if (enable) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  always_comb begin
    phase_a = state[1];
    phase_b = state[0];
  end

`ifdef TLS_PED_EN
  localparam logic [CNT_W-1:0] G_SAT  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN_CYCLES - 1);

  logic [CNT_W-1:0] g_el;
  logic [CNT_W-1:0] g_el_nxt;
  logic             pend;
  logic             pend_nxt;
  logic             ack_nxt;

  assign early = (state == GRN) && pend && (g_el >= MIN_M1);

  always_comb begin
    g_el_nxt = g_el;
    if (enable) begin
      if (state != GRN || done)
        g_el_nxt = '0;
      else if (g_el != G_SAT)
        g_el_nxt = g_el + CNT_W'(1);
    end
  end

  // a request arriving on the serving edge survives as a new request
  always_comb begin
    ack_nxt  = done && (state == YEL) && pend;
    pend_nxt = (pend && !ack_nxt) || ped_req;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      g_el    <= '0;
      pend    <= 1'b0;
      ped_ack <= 1'b0;
    end else begin
      g_el    <= g_el_nxt;
      pend    <= pend_nxt;
      ped_ack <= ack_nxt;
    end
  end
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign early          = 1'b0;
  assign ped_ack        = 1'b0;
`endif

endmodule
